// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared RAM port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_valid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
    output mem_en, mem_we, mem_size, mem_addr, mem_wdata
  );

  // Core + memory macro side.
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
    input  mem_en, mem_we, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick between fetch and load/store.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic   req_if,
  input  logic   req_ls,
  input  owner_e last_owner,
  output logic   any,
  output owner_e winner
);

  // On a tie the requester that did not own the last access wins.
  always_comb begin
    any    = req_if | req_ls;
    winner = OWN_IF;
    if (req_if && req_ls) winner = (last_owner == OWN_IF) ? OWN_LS : OWN_IF;
    else if (req_ls)      winner = OWN_LS;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported RAM between fetch and load/store, sequencing each
// granted access through WAIT_CYCLES+1 enable cycles and a valid pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic   arb_any;
  owner_e arb_win;

  rr_arb2 u_arb (
    .req_if     (bus.if_req),
    .req_ls     (bus.ls_req),
    .last_owner (last_q),
    .any        (arb_any),
    .winner     (arb_win)
  );

  // Next-state: arbitrate in IDLE, count wait states in ACCESS, pulse in RESP.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    size_d     = size_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = ACCESS;
          owner_d = arb_win;
          cnt_d   = WAIT_INIT;
          if (arb_win == OWN_IF) begin
            addr_d  = bus.if_addr;
            wdata_d = '0;
            we_d    = 1'b0;
            size_d  = SZ_D;
          end else begin
            addr_d  = bus.ls_addr;
            wdata_d = bus.ls_we ? bus.ls_wdata : '0;
            we_d    = bus.ls_we;
            size_d  = bus.ls_size;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            if (owner_q == OWN_IF) if_rdata_d = bus.mem_rdata;
            else                   ls_rdata_d = bus.mem_rdata;
          end
          last_d  = owner_q;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers; reset leaves last_owner=LS so fetch wins first.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      last_q     <= OWN_LS;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      size_q     <= size_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // Grant marks the first ACCESS cycle: the counter is still at its load value.
  assign bus.if_gnt    = (state_q == ACCESS) && (owner_q == OWN_IF) && (cnt_q == WAIT_INIT);
  assign bus.ls_gnt    = (state_q == ACCESS) && (owner_q == OWN_LS) && (cnt_q == WAIT_INIT);
  assign bus.if_valid  = (state_q == RESP) && (owner_q == OWN_IF);
  assign bus.ls_valid  = (state_q == RESP) && (owner_q == OWN_LS);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_size  = size_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (WAIT_CYCLES 0/1/3) share stimulus;
// the WAIT_CYCLES=1 instance is tracked by a valid-pulse scoreboard.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req, ls_req, ls_we;
  logic [1:0]  ls_size;
  logic [63:0] if_addr, ls_addr, ls_wdata, mem_rdata;

  logic        gif_w [3], gls_w [3], vif_w [3], vls_w [3], en_w [3], we_w [3];
  logic [1:0]  size_w [3];
  logic [63:0] addr_w [3], wdata_w [3], rdif_w [3], rdls_w [3];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { logic is_ls; logic [63:0] rdata; } exp_t;
  exp_t        sb[$];
  logic [63:0] model_if, model_ls;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : gw
    localparam int W = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();
    assign bus.if_req    = if_req;
    assign bus.if_addr   = if_addr;
    assign bus.ls_req    = ls_req;
    assign bus.ls_we     = ls_we;
    assign bus.ls_size   = ls_size;
    assign bus.ls_addr   = ls_addr;
    assign bus.ls_wdata  = ls_wdata;
    assign bus.mem_rdata = mem_rdata;
    assign gif_w[g]   = bus.if_gnt;
    assign gls_w[g]   = bus.ls_gnt;
    assign vif_w[g]   = bus.if_valid;
    assign vls_w[g]   = bus.ls_valid;
    assign en_w[g]    = bus.mem_en;
    assign we_w[g]    = bus.mem_we;
    assign size_w[g]  = bus.mem_size;
    assign addr_w[g]  = bus.mem_addr;
    assign wdata_w[g] = bus.mem_wdata;
    assign rdif_w[g]  = bus.if_rdata;
    assign rdls_w[g]  = bus.ls_rdata;
    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .WAIT_CYCLES(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
    );
  end

  // Scoreboard: every valid pulse of the WAIT_CYCLES=1 instance pops one expectation.
  always @(negedge clock) begin
    if (gif_w[1] || gls_w[1]) begin
      n_chk++;
      if (gif_w[1] && gls_w[1]) begin
        n_fail++;
        $display("FAIL dual_gnt: if_gnt=%b ls_gnt=%b, required at most one", gif_w[1], gls_w[1]);
      end
    end
    if (vif_w[1] || vls_w[1]) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_valid: if_valid=%b ls_valid=%b, required none", vif_w[1], vls_w[1]);
      end else begin
        exp_t e;
        logic [63:0] act;
        e = sb.pop_front();
        act = vls_w[1] ? rdls_w[1] : rdif_w[1];
        if ({vif_w[1], vls_w[1], act} !== {~e.is_ls, e.is_ls, e.rdata}) begin
          n_fail++;
          $display("FAIL sb_valid: got if_v=%b ls_v=%b data=%h, required if_v=%b ls_v=%b data=%h",
                   vif_w[1], vls_w[1], act, ~e.is_ls, e.is_ls, e.rdata);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    n_chk++;
    if ({gif_w[1], vif_w[1], gls_w[1], vls_w[1], en_w[1], we_w[1]} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b, required 000000",
               {gif_w[1], vif_w[1], gls_w[1], vls_w[1], en_w[1], we_w[1]});
    end
    n_chk++;
    if ({rdif_w[1], rdls_w[1], addr_w[1], wdata_w[1], size_w[1]} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: if_rdata=%h ls_rdata=%h addr=%h wdata=%h size=%b, required all 0",
               rdif_w[1], rdls_w[1], addr_w[1], wdata_w[1], size_w[1]);
    end
    model_if = '0; model_ls = '0;
    reset = 1'b0;
    cyc();
    n_chk++;
    if ({gif_w[1], gls_w[1], en_w[1]} !== 3'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: gnt/gnt/en=%b, required 000", {gif_w[1], gls_w[1], en_w[1]});
    end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 64'h40; mem_rdata = 64'hDEADBEEF;
    model_if = 64'hDEADBEEF;
    sb.push_back('{1'b0, model_if});
    for (int k = 1; k <= 4; k++) begin
      logic eg, ee, ev;
      cyc();
      eg = (k == 1); ee = (k <= 2); ev = (k == 3);
      n_chk++;
      if ({gif_w[1], en_w[1], vif_w[1]} !== {eg, ee, ev}) begin
        n_fail++;
        $display("FAIL fetch_strobes k=%0d: gnt/en/valid=%b, required %b", k,
                 {gif_w[1], en_w[1], vif_w[1]}, {eg, ee, ev});
      end
      if (ee) begin
        n_chk++;
        if ({addr_w[1], size_w[1], we_w[1]} !== {64'h40, 2'b11, 1'b0}) begin
          n_fail++;
          $display("FAIL fetch_bus k=%0d: addr=%h size=%b we=%b, required 40/11/0", k,
                   addr_w[1], size_w[1], we_w[1]);
        end
      end
      if (k == 1) if_req = 1'b0;
    end
  endtask

  task automatic test_tie();
    int ng = 0;
    int last_k = 0;
    reset = 1'b1;
    cyc(); cyc();
    model_if = '0; model_ls = '0;
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b11;
    if_addr = 64'h80; ls_addr = 64'h100; mem_rdata = 64'h1111;
    reset = 1'b0;
    for (int k = 1; k <= 40 && ng < 4; k++) begin
      cyc();
      if (gif_w[1] || gls_w[1]) begin
        logic exp_ls;
        exp_ls = (ng % 2 == 1);
        n_chk++;
        if ({gif_w[1], gls_w[1]} !== {~exp_ls, exp_ls}) begin
          n_fail++;
          $display("FAIL tie_order grant %0d: if_gnt=%b ls_gnt=%b, required %b/%b", ng,
                   gif_w[1], gls_w[1], ~exp_ls, exp_ls);
        end
        if (ng > 0) begin
          n_chk++;
          if (k - last_k != 4) begin
            n_fail++;
            $display("FAIL tie_spacing: %0d cycles, required 4", k - last_k);
          end
        end
        if (exp_ls) begin
          n_chk++;
          if (addr_w[1] !== 64'h100) begin
            n_fail++;
            $display("FAIL tie_ls_addr: %h, required 100", addr_w[1]);
          end
        end
        sb.push_back('{exp_ls, 64'h1111});
        if (exp_ls) model_ls = 64'h1111; else model_if = 64'h1111;
        last_k = k;
        ng++;
      end
    end
    n_chk++;
    if (ng != 4) begin
      n_fail++;
      $display("FAIL tie_count: %0d grants in budget, required 4", ng);
    end
    if_req = 1'b0; ls_req = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_store();
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10;
    ls_addr = 64'h200; ls_wdata = 64'h1234; mem_rdata = 64'hBAD;
    sb.push_back('{1'b1, model_ls});
    for (int k = 1; k <= 4; k++) begin
      logic eg, ee, ev;
      cyc();
      eg = (k == 1); ee = (k <= 2); ev = (k == 3);
      n_chk++;
      if ({gls_w[1], en_w[1], we_w[1], vls_w[1]} !== {eg, ee, ee, ev}) begin
        n_fail++;
        $display("FAIL store_strobes k=%0d: gnt/en/we/valid=%b, required %b", k,
                 {gls_w[1], en_w[1], we_w[1], vls_w[1]}, {eg, ee, ee, ev});
      end
      if (k <= 3) begin
        n_chk++;
        if ({addr_w[1], wdata_w[1], size_w[1]} !== {64'h200, 64'h1234, 2'b10}) begin
          n_fail++;
          $display("FAIL store_latched k=%0d: addr=%h wdata=%h size=%b, required 200/1234/10", k,
                   addr_w[1], wdata_w[1], size_w[1]);
        end
      end
      if (k == 3) begin
        n_chk++;
        if (rdls_w[1] !== model_ls) begin
          n_fail++;
          $display("FAIL store_rdata_kept: ls_rdata=%h, required %h", rdls_w[1], model_ls);
        end
      end
      if (k == 1) begin
        ls_req = 1'b0; ls_addr = 64'h999; ls_wdata = 64'hFFFF; ls_we = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 64'h300; mem_rdata = 64'h5555;
    cyc();
    n_chk++;
    if (gif_w[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_gnt: if_gnt=%b, required 1", gif_w[1]);
    end
    if_req = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    model_if = '0; model_ls = '0;
    n_chk++;
    if ({en_w[1], vif_w[1], vls_w[1], rdif_w[1]} !== {3'b0, 64'h0}) begin
      n_fail++;
      $display("FAIL midrst_abort: en=%b if_v=%b ls_v=%b if_rdata=%h, required 0/0/0/0",
               en_w[1], vif_w[1], vls_w[1], rdif_w[1]);
    end
    reset = 1'b0;
    cyc();
    if_req = 1'b1;
    model_if = 64'h5555;
    sb.push_back('{1'b0, model_if});
    for (int k = 1; k <= 4; k++) begin
      logic eg, ee, ev;
      cyc();
      eg = (k == 1); ee = (k <= 2); ev = (k == 3);
      n_chk++;
      if ({gif_w[1], en_w[1], vif_w[1]} !== {eg, ee, ev}) begin
        n_fail++;
        $display("FAIL midrst_relat k=%0d: gnt/en/valid=%b, required %b", k,
                 {gif_w[1], en_w[1], vif_w[1]}, {eg, ee, ev});
      end
      if (k == 1) if_req = 1'b0;
    end
  endtask

  task automatic test_latency();
    int en_n [3], en_first [3], val_k [3], val_n [3], gnt_n [3];
    reset = 1'b1;
    cyc(); cyc();
    model_if = '0; model_ls = '0;
    for (int g = 0; g < 3; g++) begin
      en_n[g] = 0; en_first[g] = 0; val_k[g] = 0; val_n[g] = 0; gnt_n[g] = 0;
    end
    if_req = 1'b1; if_addr = 64'h40; mem_rdata = 64'hA5A5;
    reset = 1'b0;
    model_if = 64'hA5A5;
    sb.push_back('{1'b0, model_if});
    for (int k = 1; k <= 8; k++) begin
      cyc();
      for (int g = 0; g < 3; g++) begin
        if (en_w[g]) begin
          en_n[g]++;
          if (en_first[g] == 0) en_first[g] = k;
        end
        if (vif_w[g]) begin val_n[g]++; val_k[g] = k; end
        if (gif_w[g]) gnt_n[g]++;
      end
      if (k == 1) if_req = 1'b0;
    end
    for (int g = 0; g < 3; g++) begin
      int w;
      w = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
      n_chk++;
      if (en_n[g] != w + 1 || en_first[g] != 1 || gnt_n[g] != 1) begin
        n_fail++;
        $display("FAIL lat_en wc=%0d: en cycles=%0d first=%0d gnts=%0d, required %0d/1/1",
                 w, en_n[g], en_first[g], gnt_n[g], w + 1);
      end
      n_chk++;
      if (val_k[g] != w + 2 || val_n[g] != 1) begin
        n_fail++;
        $display("FAIL lat_valid wc=%0d: valid at %0d (count %0d), required at %0d once",
                 w, val_k[g], val_n[g], w + 2);
      end
      n_chk++;
      if (rdif_w[g] !== 64'hA5A5) begin
        n_fail++;
        $display("FAIL lat_rdata wc=%0d: %h, required a5a5", w, rdif_w[g]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
    model_if = '0; model_ls = '0;
    test_reset();
    test_fetch();
    test_tie();
    test_store();
    test_reset_mid();
    test_latency();
    repeat (2) cyc();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected valids never seen, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
